// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Operation select encoding for the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of operand bits handled by one pipeline stage.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead unit. Produces the group sum for a
// given carry-in plus the group generate/propagate terms used by the
// inter-group lookahead in the parent slice.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p,
  output logic             c_out
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP:0]   carry;
  logic             g_acc;

  assign gen  = a & b;
  assign prop = a ^ b;
  assign p    = &prop;
  assign g    = g_acc;

  // Group generate: OR over bits j of gen[j] propagated through bits above j.
  // Kept independent of c_in so the parent lookahead never loops back.
  always_comb begin : group_generate
    logic term;
    term  = 1'b0;
    g_acc = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = gen[j];
      for (int m = j + 1; m < GROUP; m++) term = term & prop[m];
      g_acc = g_acc | term;
    end
  end

  // Per-bit carries in two-level lookahead form, then the sum bits.
  always_comb begin : bit_lookahead
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    carry = '0;
    for (int i = 0; i <= GROUP; i++) begin
      acc = c_in;
      for (int j = 0; j < i; j++) acc = acc & prop[j];
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int m = j + 1; m < i; m++) term = term & prop[m];
        acc = acc | term;
      end
      carry[i] = acc;
    end
    sum   = prop ^ carry[GROUP-1:0];
    c_out = carry[GROUP];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. The operand is cut into STAGES
// slices; stage k adds slice k with GROUP-bit CLA groups and lookahead across
// the groups of that slice, then registers the slice carry for stage k+1.
// Valid/ready: a transfer happens on a rising edge where valid & ready are
// both high; ready never depends combinationally on the matching valid.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int NG = SW / GROUP;

  if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES");
  end
  if (STAGES < 1 || STAGES > WIDTH / GROUP) begin : g_bad_stages
    $fatal(1, "cla_pipe_adder: STAGES must be in 1..WIDTH/GROUP");
  end

  // Stage registers: the token carries the still-needed operand bits, the
  // lower sum bits already produced and the carry into the next slice.
  logic             v_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             c_r [STAGES];
  logic             o_r [STAGES];

  // Per-stage sources (previous register or the entry operands) and results.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];
  logic             nxt_o [STAGES];

  logic [WIDTH-1:0] b_in;
  logic             c0_in;
  logic [STAGES:0]  rdy;

  // Subtraction is A + ~B + 1: invert B and force the carry-in at entry, so
  // op never needs to travel down the pipe.
  assign b_in  = (op == OP_SUB) ? ~b : b;
  assign c0_in = (op == OP_SUB) ? 1'b1 : cin;

  // Stall chain: a stage can load when it is empty or its token moves on.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = ~v_r[k] | rdy[k+1];
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = o_r[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] xa;
    logic [SW-1:0] xb;
    logic [SW-1:0] xs;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG-1:0] gco;
    logic [NG:0]   gc;
    logic [WIDTH-1:0] merged;
    logic          msb_carry_in;
    logic          unused_gco;

    if (k == 0) begin : g_entry
      assign src_v[k] = in_valid;
      assign src_a[k] = a;
      assign src_b[k] = b_in;
      assign src_s[k] = '0;
      assign src_c[k] = c0_in;
    end else begin : g_chain
      assign src_v[k] = v_r[k-1];
      assign src_a[k] = a_r[k-1];
      assign src_b[k] = b_r[k-1];
      assign src_s[k] = s_r[k-1];
      assign src_c[k] = c_r[k-1];
    end

    assign xa = src_a[k][k*SW +: SW];
    assign xb = src_b[k][k*SW +: SW];

    for (genvar g = 0; g < NG; g++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (xa[g*GROUP +: GROUP]),
        .b     (xb[g*GROUP +: GROUP]),
        .c_in  (gc[g]),
        .sum   (xs[g*GROUP +: GROUP]),
        .g     (gg[g]),
        .p     (gp[g]),
        .c_out (gco[g])
      );
    end

    // Group c_out duplicates the lookahead carries; only gc feeds the slice.
    assign unused_gco = ^gco;

    // Lookahead across the groups of this slice from group G/P terms.
    always_comb begin : slice_lookahead
      logic acc;
      logic term;
      acc  = 1'b0;
      term = 1'b0;
      gc   = '0;
      for (int i = 0; i <= NG; i++) begin
        acc = src_c[k];
        for (int j = 0; j < i; j++) acc = acc & gp[j];
        for (int j = 0; j < i; j++) begin
          term = gg[j];
          for (int m = j + 1; m < i; m++) term = term & gp[m];
          acc = acc | term;
        end
        gc[i] = acc;
      end
    end

    // Insert this slice's sum bits into the travelling partial result.
    always_comb begin
      merged              = src_s[k];
      merged[k*SW +: SW]  = xs;
    end

    // Carry into the slice MSB is recovered from the MSB sum bit; only the
    // last stage's overflow reaches the port.
    assign msb_carry_in = xa[SW-1] ^ xb[SW-1] ^ xs[SW-1];
    assign nxt_s[k]     = merged;
    assign nxt_c[k]     = gc[NG];
    assign nxt_o[k]     = msb_carry_in ^ gc[NG];
  end

  // Pipeline registers: valid bits follow the stall chain; data loads only
  // with a real token so the outputs hold through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
        o_r[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_r[k] <= src_v[k];
          if (src_v[k]) begin
            a_r[k] <= src_a[k];
            b_r[k] <= src_b[k];
            s_r[k] <= nxt_s[k];
            c_r[k] <= nxt_c[k];
            o_r[k] <= nxt_o[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 32-bit/2-stage main instance plus 8-bit/1-stage
// and 64-bit/4-stage instances, checked against an integer-arithmetic model.
module tb_cla_pipe_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT signals ----------------
  logic        in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        iv8, ir8, ci8, op8, ov8, or8, co8, of8;
  logic [7:0]  a8, b8, s8;

  logic        iv64, ir64, ci64, op64, ov64, or64, co64, of64;
  logic [63:0] a64, b64, s64;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(8), .GROUP(4), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(ci8), .op(op8), .out_valid(ov8),
    .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .cin(ci64), .op(op64), .out_valid(ov64),
    .out_ready(or64), .sum(s64), .cout(co64), .ovf(of64)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[63:0]}.
  // ovf = true signed result outside the w-bit range; cout = unsigned carry
  // (add) or "no borrow" a >= b (sub).
  function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci, input logic o);
    logic [65:0] ua, ub, u, mask;
    logic signed [65:0] sa, sb, r, hi, lo;
    logic co, ov;
    mask = (66'd1 << w) - 66'd1;
    ua = {2'b00, x} & mask;
    ub = {2'b00, y} & mask;
    sa = $signed(ua << (66 - w)) >>> (66 - w);
    sb = $signed(ub << (66 - w)) >>> (66 - w);
    if (o == 1'b0) begin
      u  = ua + ub + {65'd0, ci};
      co = u[w];
      r  = sa + sb + $signed({65'd0, ci});
    end else begin
      u  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end
    hi = $signed((66'd1 << (w - 1)) - 66'd1);
    lo = -$signed(66'd1 << (w - 1));
    ov = (r > hi) || (r < lo);
    u  = u & mask;
    return {ov, co, u[63:0]};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard for the 32-bit instance ----------------
  logic [33:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [33:0] last_out = '0;
  int          n_pop = 0;

  always @(negedge clk) begin
    logic [65:0] m;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h with no result expected (t=%0t)", sum, $time);
        end else begin
          chk("out_vs_model", {ovf, cout, sum}, exp_q[0]);
        end
        last_out = {ovf, cout, sum};
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got_q.push_back(sum);
          n_pop++;
        end
      end else begin
        chk("hold_idle", {ovf, cout, sum}, last_out);
      end
      if (in_valid && in_ready) begin
        m = model(32, {32'd0, a}, {32'd0, b}, cin, op);
        exp_q.push_back({m[65:64], m[31:0]});
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one operation and returns just after the edge that accepted it;
  // in_valid stays high so consecutive calls are back-to-back.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic top);
    logic acc;
    int   guard;
    a = ta; b = tb; cin = tc; op = top; in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("send_accept", acc, 1'b1);
  endtask

  logic bp_on = 1'b0;

  // ---------------- main sequence ----------------
  initial begin
    int t0, t1, p0, lat;
    logic [65:0] e;
    logic [65:0] q64[$];

    in_valid = 0; a = 0; b = 0; cin = 0; op = 0; out_ready = 1;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; op8 = 0; or8 = 1;
    iv64 = 0; a64 = 0; b64 = 0; ci64 = 0; op64 = 0; or64 = 1;

    // Reset state
    #1;
    chk("reset_out", {out_valid, ovf, cout, sum}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Carry through every bit; latency exactly 2
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    in_valid = 0;
    chk("lat_add_early", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_add_valid", out_valid, 1'b1);
    chk("carry_chain", {ovf, cout, sum}, {1'b0, 1'b1, 32'h0000_0000});

    // Subtraction: signed overflow, then a borrow
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h1, 1'b0, 1'b1);
    in_valid = 0;
    chk("sub_ovf", {out_valid, ovf, cout, sum}, {1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF});
    @(posedge clk); #1;
    chk("sub_borrow", {out_valid, ovf, cout, sum}, {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF});

    // Backpressure: two accepts fill the pipe, output holds
    @(posedge clk); #1;
    out_ready = 0;
    got_q.delete();
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    a = 32'd3; b = 32'd3; cin = 0; op = 0; in_valid = 1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, sum}, {1'b1, 1'b0, 32'd2});
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(32'd3, 32'd3, 1'b0, 1'b0);
    send(32'd4, 32'd4, 1'b0, 1'b0);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("bp_order%0d", i), got_q[i], 2 * (i + 1));

    // Reset with two tokens in flight
    out_ready = 0;
    send(32'd5, 32'd6, 1'b0, 1'b0);
    send(32'd7, 32'd8, 1'b0, 1'b0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid", {out_valid, ovf, cout, sum}, '0);
    exp_q.delete();
    last_out = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1;
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale", out_valid, 1'b0);

    // Full rate: 100 back-to-back random ops
    t0 = cyc;
    p0 = n_pop;
    for (int i = 0; i < 100; i++)
      send(pick32(), pick32(), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
    in_valid = 0;
    t1 = cyc;
    chk("full_rate_cycles", t1 - t0, 100);
    repeat (3) @(posedge clk);
    #1;
    chk("full_rate_pops", n_pop - p0, 100);
    chk("full_rate_drained", exp_q.size(), 0);

    // Random gaps and random backpressure
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            @(posedge clk); #1;
          end
          send(pick32(), pick32(), 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        end
        in_valid = 0;
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk); #1;
          if (bp_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_rand_drained", exp_q.size(), 0);

    // WIDTH=8, STAGES=1: latency 1
    iv8 = 1; a8 = 8'd200; b8 = 8'd100; ci8 = 1; op8 = 0;
    chk("w8_in_ready", ir8, 1'b1);
    @(posedge clk); #1;
    chk("w8_200_100_1", {ov8, of8, co8, s8}, {1'b1, 1'b0, 1'b1, 8'h2D});
    a8 = 8'd100; b8 = 8'd28; ci8 = 1; op8 = 0;
    @(posedge clk); #1;
    chk("w8_100_28_1", {ov8, of8, co8, s8}, {1'b1, 1'b1, 1'b0, 8'h81});
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      ci8 = 1'($urandom_range(0, 1)); op8 = 1'($urandom_range(0, 1));
      e = model(8, {56'd0, a8}, {56'd0, b8}, ci8, op8);
      @(posedge clk); #1;
      chk("w8_rand", {ov8, of8, co8, s8}, {1'b1, e[65:64], e[7:0]});
    end
    iv8 = 0;
    @(posedge clk); #1;
    chk("w8_idle", ov8, 1'b0);

    // WIDTH=64, STAGES=4: latency 4, carry across all stages
    iv64 = 1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd1; ci64 = 0; op64 = 0;
    @(posedge clk); #1;
    iv64 = 0;
    lat = 1;
    while (!ov64 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w64_latency", lat, 4);
    chk("w64_carry", {of64, co64, s64}, {1'b0, 1'b1, 64'd0});
    @(posedge clk); #1;
    for (int i = 0; i < 66; i++) begin
      if (ov64) begin
        if (q64.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL w64_unexpected: got %0h with no result expected", s64);
        end else begin
          chk("w64_stream", {of64, co64, s64}, q64.pop_front());
        end
      end
      if (i < 60) begin
        iv64 = 1;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        ci64 = 1'($urandom_range(0, 1)); op64 = 1'($urandom_range(0, 1));
        q64.push_back(model(64, a64, b64, ci64, op64));
      end else begin
        iv64 = 0;
      end
      @(posedge clk); #1;
    end
    chk("w64_drained", q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed 8-bit combinational CLA.
- Operand width, CLA group size and pipeline depth are generic.
- Adds a subtract mode, signed-overflow flag and a valid/ready handshake with full backpressure.
- Sits in datapath arithmetic units between operand-fetch and result-writeback streams.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*STAGES
GROUP, 4, bits per CLA group (group generate/propagate unit)
STAGES, 2, pipeline register stages; equals latency in cycles; 1..WIDTH/GROUP

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block accepts operands this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add mode only)
op  in  1  0 = add (A+B+cin), 1 = sub (A+~B+1, cin ignored)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result bits
cout  out  1  carry-out of MSB (sub mode: 1 = no borrow)
ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0): all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 once rst_n=1. Reset mid-operation discards all in-flight results; no partial output appears afterwards.
- Datapath split: WIDTH divided into STAGES slices of WIDTH/STAGES bits. Stage k adds slice k using GROUP-bit CLA groups with lookahead across groups within the slice. The slice carry-out is registered into stage k+1.
- Already-computed lower sum bits and not-yet-used upper operand bits travel with the token as pipeline registers.
- Sub mode: B inverted at entry; slice-0 carry-in forced to 1. Add mode: slice-0 carry-in = cin. op is captured at entry.
- Latency: exactly STAGES cycles from accepted input (in_valid&in_ready at edge N) to out_valid=1 after edge N+STAGES-1, when unstalled. Throughput: 1 op/cycle.
- Handshake: transfer on valid&ready at rising edge. Stage k advances when stage k+1 is empty or advancing; the last stage advances when out_ready=1 or out_valid=0.
  - in_ready = ~valid[0] | advance[0]. It is combinational from out_ready through the stall chain; no combinational path from in_valid.
- Backpressure: while out_valid=1 and out_ready=0, sum/cout/ovf and out_valid hold stable. Upstream stages fill bubbles. Once all STAGES slots are full, in_ready=0.
- Simultaneous accept and emit with a full pipeline: allowed, no bubble inserted.
- Bubbles: in_valid=0 cycles propagate as empty stages. Data registers of empty stages are don't-care, but outputs must not change while out_valid=0 after reset (hold last value).
- Wrap-around: modulo 2^WIDTH; carry beyond MSB reported only on cout.
- Elaboration check: fatal error if WIDTH % (GROUP*STAGES) != 0.

Decomposition:
- Package cla_pkg: op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1); helper function for slice width.
- Sub-module cla_group: combinational GROUP-bit CLA with inputs a, b, c_in and outputs sum, group G, group P, c_out. Instantiated WIDTH/GROUP times.
- Stage registers and handshake live in cla_pipe_adder.

Test Plan:
- Reset/idle (WIDTH=32, STAGES=2): rst_n low mid-stream with 2 tokens in flight -> out_valid=0, sum=0 immediately. After release, in_ready=1 and no stale results.
- Add carry chain: a=FFFFFFFF, b=00000001, cin=0, op=0 -> sum=00000000, cout=1, ovf=0 after exactly 2 cycles.
- Sub with borrow and signed overflow: a=80000000, b=00000001, op=1 -> sum=7FFFFFFF, cout=1, ovf=1. Then a=0, b=1, op=1 -> sum=FFFFFFFF, cout=0, ovf=0.
- Backpressure: stream 4 ops (1+1, 2+2, 3+3, 4+4) with out_ready=0 -> in_ready drops after 2 accepts and out holds 00000002. Raising out_ready yields 2, 4, 6, 8 in order, with no loss or duplication.
- Full-rate simultaneous accept/emit: 100 back-to-back random ops with out_ready=1 -> one result per cycle, matches reference model (a+b+cin, a+~b+1).
- Parameter sweep: WIDTH=8, GROUP=4, STAGES=1 and WIDTH=64, GROUP=4, STAGES=4.
  - WIDTH=8 instance: 200+100+1 -> sum=2D, cout=1; 100+28+1 -> sum=81, cout=0.
  - Latency equals STAGES in both configurations.
